// File: rtl/nn_parameters.sv
// ============================================================================
// Package : nn_parameters
// Purpose : Shared sizing constants and types for the keyword-spotting
//           network datapath. The final-layer sequencer takes its
//           frame/score geometry, final_layer latency and debounce depth
//           from here.
// Contents: OUT_SIZE_4, SCORE_W, CLASS_W, FINAL_LAT, STABLE_CNT, RUN_W,
//           score_vec_t (packed OUT_SIZE_4 x SCORE_W signed vector),
//           sat_inc() saturating run-length increment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_parameters;

  localparam int OUT_SIZE_4 = 3;   // scores per frame (final_layer width)
  localparam int SCORE_W    = 32;  // signed score width
  localparam int CLASS_W    = 2;   // class index width
  localparam int FINAL_LAT  = 2;   // final_layer input-to-output cycles
  localparam int STABLE_CNT = 3;   // identical results needed for stable
  localparam int RUN_W      = 4;   // run counter width, holds up to 15

  typedef logic signed [OUT_SIZE_4-1:0][SCORE_W-1:0] score_vec_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v,
                                               input logic [RUN_W-1:0] lim);
    return (v >= lim) ? lim : v + RUN_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/class_debounce.sv
// ============================================================================
// Module  : class_debounce
// Purpose : Tracks how many consecutive sampled classes were identical and
//           publishes a "stable" class once a run reaches STABLE_CNT. The
//           stable output is sticky: it only changes when another class
//           completes a full run, and only reset clears it.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           sample_i          - one-cycle strobe, class_i is a new result
//           class_i           - sampled class value
//           stable_class_o    - debounced class
//           stable_valid_o    - a run of STABLE_CNT has been seen
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module class_debounce
  import nn_parameters::*;
#(
  parameter int CLASS_W    = nn_parameters::CLASS_W,
  parameter int STABLE_CNT = nn_parameters::STABLE_CNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_i,
  input  logic [CLASS_W-1:0] class_i,
  output logic [CLASS_W-1:0] stable_class_o,
  output logic               stable_valid_o
);

  localparam logic [RUN_W-1:0] STABLE_LIM = RUN_W'(STABLE_CNT);

  logic [RUN_W-1:0]   run_cnt_q,      run_cnt_d;
  logic [CLASS_W-1:0] prev_class_q,   prev_class_d;
  logic [CLASS_W-1:0] stable_class_q, stable_class_d;
  logic               stable_valid_q, stable_valid_d;

  always_comb begin
    run_cnt_d      = run_cnt_q;
    prev_class_d   = prev_class_q;
    stable_class_d = stable_class_q;
    stable_valid_d = stable_valid_q;
    if (sample_i) begin
      // run_cnt==0 means no history yet, so a class matching the reset
      // value of prev_class must still start a fresh run.
      if ((class_i == prev_class_q) && (run_cnt_q != '0)) begin
        run_cnt_d = sat_inc(run_cnt_q, STABLE_LIM);
      end else begin
        run_cnt_d    = RUN_W'(1);
        prev_class_d = class_i;
      end
      if (run_cnt_d == STABLE_LIM) begin
        stable_class_d = class_i;
        stable_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q      <= '0;
      prev_class_q   <= '0;
      stable_class_q <= '0;
      stable_valid_q <= 1'b0;
    end else begin
      run_cnt_q      <= run_cnt_d;
      prev_class_q   <= prev_class_d;
      stable_class_q <= stable_class_d;
      stable_valid_q <= stable_valid_d;
    end
  end

  assign stable_class_o = stable_class_q;
  assign stable_valid_o = stable_valid_q;

endmodule

`default_nettype wire

// File: rtl/final_layer_ctrl.sv
// ============================================================================
// Module  : final_layer_ctrl
// Purpose : Sequencer in front of final_layer. Gathers OUT_SIZE_4 score
//           beats into a frozen parallel vector, waits FINAL_LAT cycles for
//           final_layer to settle, samples its class, and strobes the
//           result. Frames whose length does not match OUT_SIZE_4 are
//           dropped with an err_len pulse. A debouncer publishes a stable
//           class for downstream keyword decisions.
// Ports   : clk, rst                       - clock, sync active-high reset
//           in_score/in_valid/in_last/in_ready - layer-4 score stream
//           vec_out                        - vector to final_layer
//           cls_in                         - final_layer class output
//           result_class/result_valid      - per-frame result + strobe
//           stable_class/stable_valid      - debounced class
//           err_len                        - malformed-frame strobe
//           busy                           - not accepting beats
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module final_layer_ctrl
  import nn_parameters::*;
#(
  parameter int OUT_SIZE_4 = nn_parameters::OUT_SIZE_4,
  parameter int SCORE_W    = nn_parameters::SCORE_W,
  parameter int CLASS_W    = nn_parameters::CLASS_W,
  parameter int FINAL_LAT  = nn_parameters::FINAL_LAT,
  parameter int STABLE_CNT = nn_parameters::STABLE_CNT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic signed [SCORE_W-1:0]              in_score,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic signed [OUT_SIZE_4-1:0][SCORE_W-1:0] vec_out,
  input  logic [CLASS_W-1:0]                     cls_in,
  output logic [CLASS_W-1:0]                     result_class,
  output logic                                   result_valid,
  output logic [CLASS_W-1:0]                     stable_class,
  output logic                                   stable_valid,
  output logic                                   err_len,
  output logic                                   busy
);

  localparam int IDX_W  = (OUT_SIZE_4 > 1) ? $clog2(OUT_SIZE_4) : 1;
  localparam int WAIT_W = (FINAL_LAT > 1) ? $clog2(FINAL_LAT) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(OUT_SIZE_4 - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((FINAL_LAT > 0) ? FINAL_LAT - 1 : 0);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WAIT    = 2'd1,
    ST_SAMPLE  = 2'd2
  } state_t;

  state_t                                   state_q, state_d;
  logic [IDX_W-1:0]                         idx_q, idx_d;
  logic [WAIT_W-1:0]                        wait_cnt_q, wait_cnt_d;
  logic signed [OUT_SIZE_4-1:0][SCORE_W-1:0] vec_q, vec_d;
  logic [CLASS_W-1:0]                       result_class_q, result_class_d;
  logic                                     result_valid_q, result_valid_d;
  logic                                     err_len_q, err_len_d;
  logic                                     accept;
  logic                                     wr_en;
  logic                                     sample;

  assign accept = in_valid && (state_q == ST_COLLECT);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wait_cnt_d     = wait_cnt_q;
    result_class_d = result_class_q;
    result_valid_d = 1'b0;
    err_len_d      = 1'b0;
    wr_en          = 1'b0;
    sample         = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          // Every accepted beat lands in the vector, including the beat that
          // reveals a length error; a dropped frame's contents are don't-care.
          wr_en = 1'b1;
          if ((idx_q == IDX_LAST) && in_last) begin
            idx_d      = '0;
            wait_cnt_d = '0;
            state_d    = (FINAL_LAT == 0) ? ST_SAMPLE : ST_WAIT;
          end else if ((idx_q != IDX_LAST) && !in_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            err_len_d = 1'b1;
            idx_d     = '0;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        sample         = 1'b1;
        result_class_d = cls_in;
        result_valid_d = 1'b1;
        state_d        = ST_COLLECT;
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_comb begin
    vec_d = vec_q;
    for (int k = 0; k < OUT_SIZE_4; k++) begin
      if (wr_en && (idx_q == IDX_W'(k))) begin
        vec_d[k] = in_score;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_COLLECT;
      idx_q          <= '0;
      wait_cnt_q     <= '0;
      vec_q          <= '0;
      result_class_q <= '0;
      result_valid_q <= 1'b0;
      err_len_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wait_cnt_q     <= wait_cnt_d;
      vec_q          <= vec_d;
      result_class_q <= result_class_d;
      result_valid_q <= result_valid_d;
      err_len_q      <= err_len_d;
    end
  end

  class_debounce #(
    .CLASS_W    (CLASS_W),
    .STABLE_CNT (STABLE_CNT)
  ) u_debounce (
    .clk            (clk),
    .rst            (rst),
    .sample_i       (sample),
    .class_i        (cls_in),
    .stable_class_o (stable_class),
    .stable_valid_o (stable_valid)
  );

  assign in_ready     = (state_q == ST_COLLECT);
  assign busy         = (state_q != ST_COLLECT);
  assign vec_out      = vec_q;
  assign result_class = result_class_q;
  assign result_valid = result_valid_q;
  assign err_len      = err_len_q;

endmodule

`default_nettype wire

// File: tb/tb_final_layer_ctrl.sv
// ============================================================================
// Module  : tb_final_layer_ctrl
// Purpose : Self-checking bench for final_layer_ctrl. final_layer is stood
//           in for by an argmax delayed FINAL_LAT cycles. The reference
//           model works at frame level: a count of beats in the current
//           frame, a countdown of blocked cycles after a good frame, and a
//           history list of results from which the stable class is derived.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_final_layer_ctrl;
  import nn_parameters::*;

  localparam int N = OUT_SIZE_4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic signed [SCORE_W-1:0] in_score = '0;
  logic                     in_valid = 1'b0;
  logic                     in_last = 1'b0;
  logic                     in_ready;
  score_vec_t               vec_out;
  logic [CLASS_W-1:0]       cls_in;
  logic [CLASS_W-1:0]       result_class;
  logic                     result_valid;
  logic [CLASS_W-1:0]       stable_class;
  logic                     stable_valid;
  logic                     err_len;
  logic                     busy;

  always #5 clk = ~clk;

  final_layer_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_score     (in_score),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .vec_out      (vec_out),
    .cls_in       (cls_in),
    .result_class (result_class),
    .result_valid (result_valid),
    .stable_class (stable_class),
    .stable_valid (stable_valid),
    .err_len      (err_len),
    .busy         (busy)
  );

  // Index of the largest score; the lowest index wins a tie.
  function automatic logic [CLASS_W-1:0] argmax(input score_vec_t v);
    int best;
    best = 0;
    for (int k = 1; k < N; k++) begin
      if ($signed(v[k]) > $signed(v[best])) best = k;
    end
    return CLASS_W'(best);
  endfunction

  // Behavioural final_layer: argmax of its input, FINAL_LAT cycles late.
  logic [CLASS_W-1:0] fl_pipe [FINAL_LAT];
  always @(posedge clk) begin
    fl_pipe[0] <= argmax(vec_out);
    for (int i = 1; i < FINAL_LAT; i++) fl_pipe[i] <= fl_pipe[i-1];
  end
  assign cls_in = fl_pipe[FINAL_LAT-1];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                 m_live = 0;
  int                 m_vec [N];
  int                 m_len;
  int                 m_blocked;
  int                 m_res_cd;
  logic [CLASS_W-1:0] m_pend;
  logic [CLASS_W-1:0] m_rc;
  bit                 m_rv;
  bit                 m_err;
  logic [CLASS_W-1:0] m_sc;
  bit                 m_sv;
  bit                 m_acc;
  int                 hist [$];

  function automatic score_vec_t pack_model();
    score_vec_t v;
    for (int k = 0; k < N; k++) v[k] = m_vec[k];
    return v;
  endfunction

  task automatic model_step(input bit v, input int s, input bit l, input bit r);
    int run;
    m_acc = 0;
    if (r) begin
      for (int k = 0; k < N; k++) m_vec[k] = 0;
      m_len = 0; m_blocked = 0; m_res_cd = 0; m_pend = '0;
      m_rc = '0; m_rv = 0; m_err = 0; m_sc = '0; m_sv = 0;
      hist.delete();
      m_live = 1;
    end else begin
      m_rv  = 0;
      m_err = 0;
      if (m_res_cd > 0) begin
        m_res_cd--;
        if (m_res_cd == 0) begin
          m_rv = 1;
          m_rc = m_pend;
          hist.push_back(int'(m_pend));
          run = 0;
          for (int j = hist.size() - 1; j >= 0; j--) begin
            if (hist[j] != int'(m_pend)) break;
            run++;
          end
          if (run >= STABLE_CNT) begin
            m_sc = m_pend;
            m_sv = 1;
          end
        end
      end
      if (m_blocked > 0) begin
        m_blocked--;
      end else if (v) begin
        m_acc = 1;
        m_vec[m_len] = s;
        m_len++;
        if (m_len == N && l) begin
          m_blocked = FINAL_LAT + 1;
          m_res_cd  = FINAL_LAT + 1;
          m_pend    = argmax(pack_model());
          m_len     = 0;
        end else if (l || m_len == N) begin
          m_err = 1;
          m_len = 0;
        end
      end
    end
  endtask

  // ---------------- cycle driver ----------------
  bit                 obs_rv;
  logic [CLASS_W-1:0] obs_rc;
  int                 rv_seen = 0;

  task automatic tick(input bit v, input int s, input bit l, input bit r);
    @(negedge clk);
    obs_rv = result_valid;
    obs_rc = result_class;
    if (result_valid) rv_seen++;
    if (m_live) begin
      check_val("in_ready",     in_ready,     m_blocked == 0);
      check_val("busy",         busy,         m_blocked != 0);
      check_val("result_valid", result_valid, m_rv);
      check_val("result_class", result_class, m_rc);
      check_val("stable_valid", stable_valid, m_sv);
      check_val("stable_class", stable_class, m_sc);
      check_val("err_len",      err_len,      m_err);
      check_val("vec_out",      vec_out,      pack_model());
    end
    in_valid = v;
    in_score = s;
    in_last  = l;
    rst      = r;
    model_step(v, s, l, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  task automatic send_frame(input int a, input int b, input int c);
    tick(1, a, 0, 0);
    tick(1, b, 0, 0);
    tick(1, c, 1, 0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int lat;
    int rv0;
    int b;
    int guard;
    int used;
    int sc [N];
    bit v, l, r;

    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);

    // 1: nominal frame and its latency from the last accept
    send_frame(500, 300000, 2000000);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 0, 0);
      if (lat == 0 && obs_rv) begin
        lat = k;
        check_val("t1_class", obs_rc, 2);
      end
    end
    check_val("t1_latency", lat, FINAL_LAT + 2);

    // 2: debounce, three class-2 frames then class 0 (three times)
    send_frame(1, 2, 3);   idle(4);
    send_frame(-5, 0, 9);  idle(4);
    send_frame(9, 0, 1);   idle(4);
    send_frame(8, 1, 2);   idle(4);
    send_frame(8, 1, 2);   idle(4);

    // 3: short frame, over-long stream, then a good frame
    tick(1, 4, 0, 0); tick(1, 5, 1, 0); idle(2);
    tick(1, 1, 0, 0); tick(1, 2, 0, 0); tick(1, 3, 0, 0); tick(1, 4, 1, 0);
    idle(2);
    send_frame(-7, -3, -9); idle(5);

    // 4: gaps during collect, in_valid held high while blocked
    tick(1, 11, 0, 0); tick(0, 0, 0, 0);
    tick(1, 33, 0, 0); tick(0, 0, 0, 0);
    tick(1, 22, 1, 0);
    for (int i = 0; i < FINAL_LAT + 1; i++) tick(1, 99, 0, 0);
    send_frame(0, 0, 7); idle(5);

    // 5: reset while waiting on final_layer
    send_frame(1, 2, 3);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    idle(1);
    send_frame(10, 20, 5); idle(5);

    // 6: back-to-back frames, source holds each beat until accepted
    rv0  = rv_seen;
    used = 0;
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < N; k++) sc[k] = int'($urandom);
      b = 0;
      guard = 0;
      while (b < N && guard < 50) begin
        tick(1, sc[b], b == N - 1, 0);
        used++;
        if (m_acc) b++;
        guard++;
      end
      if (b != N) check_val("b2b_stall", b, N);
    end
    check_val("b2b_cycles", used, 20 * (N + FINAL_LAT + 1) - (FINAL_LAT + 1));
    idle(FINAL_LAT + 3);
    check_val("b2b_results", rv_seen - rv0, 20);

    // 7: random traffic with occasional length errors and resets
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      l = (m_len == N - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 149) == 0);
      tick(v, int'($urandom_range(0, 6)) - 3, l, r);
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
